ym3438_lfo_mod: RTL and testbench

//  Consumes the 7-bit LFO counter and turns it into per-slot tremolo (AM) and vibrato (PM) terms.
//  The block snapshots the counter once per 24-slot cycle, then pipelines each slot's channel AMS/PMS.
//  The AM term feeds the envelope generator; the PM term feeds the phase generator's fnum offset stage.

---
 rtl/ym3438_pkg.sv | 28 ++
 rtl/ym3438_lfo_am_shape.sv | 24 ++
 rtl/ym3438_lfo_mod.sv | 133 +++++++++++++
 tb/tb_ym3438_lfo_mod.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ym3438_pkg.sv
// Shared YM3438 LFO definitions: slot count, bus widths, PM payload, AMS shift lookup.
package ym3438_pkg;

  localparam int unsigned SLOTS  = 24;
  localparam int unsigned SLOT_W = 5;
  localparam int unsigned LFO_W  = 7;
  localparam int unsigned AM_W   = 7;

  // Vibrato payload handed to the phase generator.
  typedef struct packed {
    logic       neg;
    logic [2:0] q;
    logic [2:0] pms;
  } lfo_pm_t;

  // AMS -> right shift of the 7-bit tremolo depth; 8 shifts everything out (no tremolo).
  function automatic logic [3:0] ams_shift(input logic [1:0] ams);
    logic [3:0] sh;
    case (ams)
      2'd0:    sh = 4'd8;
      2'd1:    sh = 4'd3;
      2'd2:    sh = 4'd1;
      default: sh = 4'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/ym3438_lfo_am_shape.sv
// Tremolo shaping: folds the held LFO count into a 0..63 triangle, doubles it and applies the AMS shift.
// Ports:
//   hold     in  7  snapshotted LFO counter
//   ams      in  2  channel AMS
//   am_out_c out 7  tremolo attenuation (combinational)
module ym3438_lfo_am_shape
  import ym3438_pkg::*;
(
  input  logic [LFO_W-1:0] hold,
  input  logic [1:0]       ams,
  output logic [AM_W-1:0]  am_out_c
);

  logic [5:0]      am_raw;
  logic [AM_W-1:0] am_full;

  always_comb begin
    // Lower half of the LFO period counts down, upper half counts up.
    am_raw   = hold[6] ? hold[5:0] : ~hold[5:0];
    am_full  = {am_raw, 1'b0};
    am_out_c = am_full >> ams_shift(ams);
  end

endmodule

// File: rtl/ym3438_lfo_mod.sv
// LFO modulation: snapshots the LFO counter once per 24-slot cycle and pipelines per-slot
// tremolo (AM) and vibrato (PM) terms over two strobes.
// Ports:
//   MCLK      in   1  clock
//   IC        in   1  synchronous active-high reset
//   c1        in   1  slot strobe; all state advances only when set
//   fsm_sel23 in   1  last slot of the cycle (qualified by c1)
//   lfo_en    in   1  LFO enable
//   lfo_cnt   in   7  LFO counter
//   ams       in   2  AMS of the current slot's channel
//   pms       in   3  PMS of the current slot's channel
//   am_out    out  7  tremolo attenuation
//   pm_q      out  3  mirrored vibrato quarter-wave index
//   pm_neg    out  1  vibrato sign
//   pm_pms    out  3  pipelined PMS (0 = no vibrato)
//   slot_idx  out  5  slot matching the current outputs
module ym3438_lfo_mod
  import ym3438_pkg::*;
(
  input  logic              MCLK,
  input  logic              IC,
  input  logic              c1,
  input  logic              fsm_sel23,
  input  logic              lfo_en,
  input  logic [LFO_W-1:0]  lfo_cnt,
  input  logic [1:0]        ams,
  input  logic [2:0]        pms,
  output logic [AM_W-1:0]   am_out,
  output logic [2:0]        pm_q,
  output logic              pm_neg,
  output logic [2:0]        pm_pms,
  output logic [SLOT_W-1:0] slot_idx
);

  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [LFO_W-1:0]  lfo_hold_q, lfo_hold_d;
  logic              hold_en_q, hold_en_d;
  logic [1:0]        a_ams_q, a_ams_d;
  logic [2:0]        a_pms_q, a_pms_d;
  logic [LFO_W-1:0]  a_hold_q, a_hold_d;
  logic              a_en_q, a_en_d;
  logic [SLOT_W-1:0] a_slot_q, a_slot_d;
  logic [AM_W-1:0]   am_out_q, am_out_d;
  lfo_pm_t           pm_q_q, pm_q_d;
  logic [SLOT_W-1:0] slot_idx_q, slot_idx_d;

  logic [AM_W-1:0]   am_shaped_c;
  logic [4:0]        p_c;

  ym3438_lfo_am_shape u_am_shape (
    .hold     (a_hold_q),
    .ams      (a_ams_q),
    .am_out_c (am_shaped_c)
  );

  // Next-state for snapshot, slot counter and both pipe stages.
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    lfo_hold_d = lfo_hold_q;
    hold_en_d  = hold_en_q;
    a_ams_d    = a_ams_q;
    a_pms_d    = a_pms_q;
    a_hold_d   = a_hold_q;
    a_en_d     = a_en_q;
    a_slot_d   = a_slot_q;
    am_out_d   = am_out_q;
    pm_q_d     = pm_q_q;
    slot_idx_d = slot_idx_q;
    p_c        = a_hold_q[6:2];

    if (c1) begin
      // Resync on the last slot wins over the natural wrap.
      if (fsm_sel23) begin
        slot_cnt_d = '0;
        lfo_hold_d = lfo_en ? lfo_cnt : '0;
        hold_en_d  = lfo_en;
      end else if (slot_cnt_q == SLOT_W'(SLOTS - 1)) begin
        slot_cnt_d = '0;
      end else begin
        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
      end

      a_ams_d  = ams;
      a_pms_d  = pms;
      a_hold_d = lfo_hold_q;
      a_en_d   = hold_en_q;
      a_slot_d = slot_cnt_q;

      // A disabled snapshot suppresses both tremolo and vibrato for that slot.
      am_out_d   = a_en_q ? am_shaped_c : '0;
      pm_q_d.q   = p_c[3] ? ~p_c[2:0] : p_c[2:0];
      pm_q_d.neg = p_c[4];
      pm_q_d.pms = a_en_q ? a_pms_q : 3'd0;
      slot_idx_d = a_slot_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge MCLK) begin
    if (IC) begin
      slot_cnt_q <= '0;
      lfo_hold_q <= '0;
      hold_en_q  <= 1'b0;
      a_ams_q    <= '0;
      a_pms_q    <= '0;
      a_hold_q   <= '0;
      a_en_q     <= 1'b0;
      a_slot_q   <= '0;
      am_out_q   <= '0;
      pm_q_q     <= '0;
      slot_idx_q <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      lfo_hold_q <= lfo_hold_d;
      hold_en_q  <= hold_en_d;
      a_ams_q    <= a_ams_d;
      a_pms_q    <= a_pms_d;
      a_hold_q   <= a_hold_d;
      a_en_q     <= a_en_d;
      a_slot_q   <= a_slot_d;
      am_out_q   <= am_out_d;
      pm_q_q     <= pm_q_d;
      slot_idx_q <= slot_idx_d;
    end
  end

  assign am_out   = am_out_q;
  assign pm_q     = pm_q_q.q;
  assign pm_neg   = pm_q_q.neg;
  assign pm_pms   = pm_q_q.pms;
  assign slot_idx = slot_idx_q;

endmodule

// File: tb/tb_ym3438_lfo_mod.sv
// Directed bench for ym3438_lfo_mod.
module tb_ym3438_lfo_mod;

  logic       MCLK = 1'b0;
  logic       IC = 1'b1;
  logic       c1 = 1'b0;
  logic       fsm_sel23 = 1'b0;
  logic       lfo_en = 1'b0;
  logic [6:0] lfo_cnt = 7'd0;
  logic [1:0] ams = 2'd0;
  logic [2:0] pms = 3'd0;
  logic [6:0] am_out;
  logic [2:0] pm_q;
  logic       pm_neg;
  logic [2:0] pm_pms;
  logic [4:0] slot_idx;

  int checks = 0;
  int failures = 0;

  always #5 MCLK = ~MCLK;

  ym3438_lfo_mod dut (
    .MCLK      (MCLK),
    .IC        (IC),
    .c1        (c1),
    .fsm_sel23 (fsm_sel23),
    .lfo_en    (lfo_en),
    .lfo_cnt   (lfo_cnt),
    .ams       (ams),
    .pms       (pms),
    .am_out    (am_out),
    .pm_q      (pm_q),
    .pm_neg    (pm_neg),
    .pm_pms    (pm_pms),
    .slot_idx  (slot_idx)
  );

  // One c1 strobe followed by an idle MCLK; returns at a negedge.
  task automatic strobe(input logic sel, input logic [6:0] cnt, input logic [1:0] a,
                        input logic [2:0] p, input logic en);
    @(negedge MCLK);
    fsm_sel23 = sel;
    lfo_cnt   = cnt;
    ams       = a;
    pms       = p;
    lfo_en    = en;
    c1        = 1'b1;
    @(negedge MCLK);
    c1        = 1'b0;
    fsm_sel23 = 1'b0;
    @(negedge MCLK);
  endtask

  task automatic test_reset;
    IC = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge MCLK);
      c1 = ~c1;
    end
    @(negedge MCLK);
    c1 = 1'b0;
    checks++;
    if ({am_out, pm_q, pm_neg, pm_pms, slot_idx} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got am=%0d q=%0d neg=%0d pms=%0d slot=%0d exp all 0",
               am_out, pm_q, pm_neg, pm_pms, slot_idx);
    end
    IC = 1'b0;
    for (int i = 0; i < 2; i++) begin
      strobe(1'b0, 7'h55, 2'd3, 3'd7, 1'b1);
      checks++;
      if ({am_out, pm_q, pm_neg, pm_pms, slot_idx} !== 19'd0) begin
        failures++;
        $display("FAIL post_reset_%0d got am=%0d q=%0d neg=%0d pms=%0d slot=%0d exp all 0",
                 i, am_out, pm_q, pm_neg, pm_pms, slot_idx);
      end
    end
  endtask

  task automatic test_am_triangle;
    logic [6:0] cnts [4];
    logic [6:0] exps [4];
    cnts = '{7'h00, 7'h40, 7'h7F, 7'h3F};
    exps = '{7'd126, 7'd0, 7'd126, 7'd0};
    for (int i = 0; i < 4; i++) begin
      strobe(1'b1, cnts[i], 2'd3, 3'd0, 1'b1);
      strobe(1'b0, 7'h00, 2'd3, 3'd0, 1'b1);
      strobe(1'b0, 7'h00, 2'd3, 3'd0, 1'b1);
      checks++;
      if (am_out !== exps[i] || slot_idx !== 5'd0) begin
        failures++;
        $display("FAIL am_triangle cnt=%0h got am=%0d slot=%0d exp am=%0d slot=0",
                 cnts[i], am_out, slot_idx, exps[i]);
      end
    end
  endtask

  task automatic test_ams_shift;
    strobe(1'b1, 7'h10, 2'd3, 3'd0, 1'b1);
    strobe(1'b0, 7'h00, 2'd1, 3'd0, 1'b1);
    strobe(1'b0, 7'h00, 2'd2, 3'd0, 1'b1);
    checks++;
    if (am_out !== 7'd11) begin
      failures++;
      $display("FAIL ams1 got %0d exp 11", am_out);
    end
    strobe(1'b0, 7'h00, 2'd0, 3'd0, 1'b1);
    checks++;
    if (am_out !== 7'd47) begin
      failures++;
      $display("FAIL ams2 got %0d exp 47", am_out);
    end
    strobe(1'b0, 7'h00, 2'd3, 3'd0, 1'b1);
    checks++;
    if (am_out !== 7'd0) begin
      failures++;
      $display("FAIL ams0 got %0d exp 0", am_out);
    end
    strobe(1'b0, 7'h00, 2'd3, 3'd0, 1'b1);
    checks++;
    if (am_out !== 7'd94) begin
      failures++;
      $display("FAIL ams3 got %0d exp 94", am_out);
    end
  endtask

  task automatic test_pm_mirror;
    logic [6:0] cnts [3];
    logic [2:0] qs [3];
    logic       negs [3];
    cnts = '{7'h0C, 7'h2C, 7'h6C};
    qs   = '{3'd3, 3'd4, 3'd4};
    negs = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1, cnts[i], 2'd0, 3'd5, 1'b1);
      strobe(1'b0, 7'h00, 2'd0, 3'd5, 1'b1);
      strobe(1'b0, 7'h00, 2'd0, 3'd5, 1'b1);
      checks++;
      if (pm_q !== qs[i] || pm_neg !== negs[i] || pm_pms !== 3'd5) begin
        failures++;
        $display("FAIL pm_mirror cnt=%0h got q=%0d neg=%0d pms=%0d exp q=%0d neg=%0d pms=5",
                 cnts[i], pm_q, pm_neg, pm_pms, qs[i], negs[i]);
      end
    end
  endtask

  task automatic test_c1_idle;
    strobe(1'b1, 7'h6C, 2'd3, 3'd5, 1'b1);
    strobe(1'b0, 7'h00, 2'd3, 3'd5, 1'b1);
    strobe(1'b0, 7'h00, 2'd3, 3'd5, 1'b1);
    checks++;
    if (am_out !== 7'd88 || pm_q !== 3'd4 || pm_neg !== 1'b1 || pm_pms !== 3'd5 || slot_idx !== 5'd0) begin
      failures++;
      $display("FAIL idle_pre got am=%0d q=%0d neg=%0d pms=%0d slot=%0d exp 88 4 1 5 0",
               am_out, pm_q, pm_neg, pm_pms, slot_idx);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge MCLK);
      fsm_sel23 = 1'b1;
      lfo_cnt   = 7'($urandom_range(0, 127));
      ams       = 2'd0;
      pms       = 3'd0;
      lfo_en    = 1'b0;
    end
    @(negedge MCLK);
    fsm_sel23 = 1'b0;
    checks++;
    if (am_out !== 7'd88 || pm_q !== 3'd4 || pm_neg !== 1'b1 || pm_pms !== 3'd5 || slot_idx !== 5'd0) begin
      failures++;
      $display("FAIL idle_hold got am=%0d q=%0d neg=%0d pms=%0d slot=%0d exp 88 4 1 5 0",
               am_out, pm_q, pm_neg, pm_pms, slot_idx);
    end
    strobe(1'b0, 7'h00, 2'd3, 3'd5, 1'b1);
    strobe(1'b0, 7'h00, 2'd3, 3'd5, 1'b1);
    checks++;
    if (slot_idx !== 5'd2 || am_out !== 7'd88) begin
      failures++;
      $display("FAIL idle_sel23_ignored got slot=%0d am=%0d exp slot=2 am=88", slot_idx, am_out);
    end
  endtask

  task automatic test_snapshot_hold;
    strobe(1'b1, 7'h00, 2'd3, 3'd0, 1'b1);
    for (int k = 0; k < 24; k++) begin
      strobe(k == 23, (k == 23) ? 7'h40 : 7'(k * 5 + 1), 2'd3, 3'd0, 1'b1);
      if (k >= 1) begin
        checks++;
        if (am_out !== 7'd126 || slot_idx !== 5'(k - 1)) begin
          failures++;
          $display("FAIL snapshot_hold k=%0d got am=%0d slot=%0d exp am=126 slot=%0d",
                   k, am_out, slot_idx, k - 1);
        end
      end
    end
    strobe(1'b0, 7'h11, 2'd3, 3'd0, 1'b1);
    checks++;
    if (am_out !== 7'd126 || slot_idx !== 5'd23) begin
      failures++;
      $display("FAIL snapshot_last_slot got am=%0d slot=%0d exp am=126 slot=23", am_out, slot_idx);
    end
    strobe(1'b0, 7'h22, 2'd3, 3'd0, 1'b1);
    checks++;
    if (am_out !== 7'd0 || slot_idx !== 5'd0) begin
      failures++;
      $display("FAIL snapshot_new_cycle got am=%0d slot=%0d exp am=0 slot=0", am_out, slot_idx);
    end
  endtask

  task automatic test_disable_resync;
    strobe(1'b1, 7'h10, 2'd3, 3'd5, 1'b0);
    for (int i = 0; i <= 10; i++) begin
      strobe(i == 10, 7'h00, 2'd3, 3'd5, 1'b1);
      if (i >= 2) begin
        checks++;
        if (am_out !== 7'd0 || pm_pms !== 3'd0 || slot_idx !== 5'(i - 1)) begin
          failures++;
          $display("FAIL disabled i=%0d got am=%0d pms=%0d slot=%0d exp am=0 pms=0 slot=%0d",
                   i, am_out, pm_pms, slot_idx, i - 1);
        end
      end
    end
    strobe(1'b0, 7'h00, 2'd3, 3'd5, 1'b1);
    checks++;
    if (slot_idx !== 5'd10 || am_out !== 7'd0 || pm_pms !== 3'd0) begin
      failures++;
      $display("FAIL resync_slot10 got slot=%0d am=%0d pms=%0d exp slot=10 am=0 pms=0",
               slot_idx, am_out, pm_pms);
    end
    strobe(1'b0, 7'h00, 2'd3, 3'd5, 1'b1);
    checks++;
    if (slot_idx !== 5'd0 || am_out !== 7'd126 || pm_pms !== 3'd5) begin
      failures++;
      $display("FAIL resync_slot0 got slot=%0d am=%0d pms=%0d exp slot=0 am=126 pms=5",
               slot_idx, am_out, pm_pms);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge MCLK);
    IC = 1'b1;
    c1 = 1'b1;
    @(negedge MCLK);
    IC = 1'b0;
    c1 = 1'b0;
    checks++;
    if (am_out !== 7'd0 || pm_pms !== 3'd0 || slot_idx !== 5'd0) begin
      failures++;
      $display("FAIL mid_reset got am=%0d pms=%0d slot=%0d exp 0 0 0", am_out, pm_pms, slot_idx);
    end
    strobe(1'b0, 7'h00, 2'd3, 3'd5, 1'b1);
    strobe(1'b0, 7'h00, 2'd3, 3'd5, 1'b1);
    checks++;
    if (am_out !== 7'd0 || pm_pms !== 3'd0 || slot_idx !== 5'd0) begin
      failures++;
      $display("FAIL mid_reset_flushed got am=%0d pms=%0d slot=%0d exp 0 0 0", am_out, pm_pms, slot_idx);
    end
    strobe(1'b1, 7'h00, 2'd3, 3'd5, 1'b1);
    strobe(1'b0, 7'h00, 2'd3, 3'd5, 1'b1);
    strobe(1'b0, 7'h00, 2'd3, 3'd5, 1'b1);
    checks++;
    if (am_out !== 7'd126 || pm_pms !== 3'd5) begin
      failures++;
      $display("FAIL mid_reset_resnap got am=%0d pms=%0d exp am=126 pms=5", am_out, pm_pms);
    end
  endtask

  initial begin
    test_reset;
    test_am_triangle;
    test_ams_shift;
    test_pm_mirror;
    test_c1_idle;
    test_snapshot_hold;
    test_disable_resync;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
